// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bundle: requester handshake, regfile write port and bypass compare.
// The master side is the requesters/read stage; the slave side is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    logic                          rf_we;
    logic [ADDR_WIDTH-1:0]         rf_w_addr;
    logic [DATA_WIDTH-1:0]         rf_w_data;
    logic [ID_W-1:0]               wb_id;

    logic [ADDR_WIDTH-1:0]         rd_addr1;
    logic [ADDR_WIDTH-1:0]         rd_addr2;
    logic                          fwd_hit1;
    logic                          fwd_hit2;
    logic [DATA_WIDTH-1:0]         fwd_data;

    modport master (
        output req_valid, req_addr, req_data, rd_addr1, rd_addr2,
        input  req_ready, rf_we, rf_w_addr, rf_w_data, wb_id,
               fwd_hit1, fwd_hit2, fwd_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, rd_addr1, rd_addr2,
        output req_ready, rf_we, rf_w_addr, rf_w_data, wb_id,
               fwd_hit1, fwd_hit2, fwd_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding a registered regfile write stage; 1-cycle latency to rf_we.
// Never stalls: one grant per cycle while any request is valid; address 0 is accepted but not written.
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave wb
);
    localparam int              ID_W    = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_w_addr_q, rf_w_addr_d;
    logic [DATA_WIDTH-1:0] rf_w_data_q, rf_w_data_d;
    logic [ID_W-1:0]       wb_id_q, wb_id_d;

    logic [NUM_REQ-1:0]    hi_mask;
    logic [NUM_REQ-1:0]    masked_vld;
    logic [NUM_REQ-1:0]    pick_src;
    logic                  win_vld;
    logic [ID_W-1:0]       win_id;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_data;

    // Requests at or above the pointer take precedence; if none, wrap to the lowest valid index.
    always_comb begin
        hi_mask  = '0;
        win_vld  = 1'b0;
        win_id   = '0;
        grant_oh = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (ID_W'(i) >= ptr_q);
        end
        masked_vld = wb.req_valid & hi_mask;
        pick_src   = (|masked_vld) ? masked_vld : wb.req_valid;
        win_vld    = |pick_src;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                win_id = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = win_vld && (ID_W'(i) == win_id);
            if (grant_oh[i]) begin
                win_addr = wb.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = wb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        rf_we_d     = 1'b0;
        rf_w_addr_d = rf_w_addr_q;
        rf_w_data_d = rf_w_data_q;
        wb_id_d     = wb_id_q;
        if (win_vld) begin
            ptr_d       = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);
            rf_we_d     = (win_addr != '0);
            rf_w_addr_d = win_addr;
            rf_w_data_d = win_data;
            wb_id_d     = win_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_w_addr_q <= '0;
            rf_w_data_q <= '0;
            wb_id_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rf_we_q     <= rf_we_d;
            rf_w_addr_q <= rf_w_addr_d;
            rf_w_data_q <= rf_w_data_d;
            wb_id_q     <= wb_id_d;
        end
    end

    // Grants are suppressed while reset is held so no requester believes it was accepted.
    assign wb.req_ready = rst_n ? grant_oh : '0;

    assign wb.rf_we     = rf_we_q;
    assign wb.rf_w_addr = rf_w_addr_q;
    assign wb.rf_w_data = rf_w_data_q;
    assign wb.wb_id     = wb_id_q;

    assign wb.fwd_hit1  = rf_we_q && (rf_w_addr_q == wb.rd_addr1) && (wb.rd_addr1 != '0);
    assign wb.fwd_hit2  = rf_we_q && (rf_w_addr_q == wb.rd_addr2) && (wb.rd_addr2 != '0);
    assign wb.fwd_data  = rf_w_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table with a stage scoreboard, then starvation and reset sequences.
module tb_regfile_wb_arbiter;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    // Behavioural regfile written from the DUT's write port.
    logic [31:0] rf_mem [32] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_w_addr] <= bus.rf_w_data;
    end

    typedef struct {
        logic [2:0]  vld;
        logic [4:0]  a0, a1, a2;
        logic [31:0] base;
        logic [4:0]  rd1, rd2;
        logic [2:0]  exp_rdy;
        logic        exp_we;
        logic [1:0]  exp_id;
        logic        exp_f1, exp_f2;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  id;
    } stage_t;

    vec_t   vecs[16];
    stage_t sb_q[$];
    stage_t cur_exp;
    stage_t last_push;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] vld, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [31:0] base, input logic [4:0] rd1,
                                input logic [4:0] rd2, input logic [2:0] rdy, input logic we,
                                input logic [1:0] id, input logic f1, input logic f2);
        vec_t v;
        v.vld = vld; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.base = base;
        v.rd1 = rd1; v.rd2 = rd2; v.exp_rdy = rdy; v.exp_we = we; v.exp_id = id;
        v.exp_f1 = f1; v.exp_f2 = f2;
        return v;
    endfunction

    // Requester i presents data base+i.
    task automatic drive(input logic [2:0] vld, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [31:0] base, input logic [4:0] rd1,
                         input logic [4:0] rd2);
        bus.req_valid = vld;
        bus.req_addr  = {a2, a1, a0};
        bus.req_data  = {base + 32'd2, base + 32'd1, base};
        bus.rd_addr1  = rd1;
        bus.rd_addr2  = rd2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        //                vld     a0     a1     a2     base           rd1    rd2    rdy     we    id     f1    f2
        vecs[0]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      5'd0,  5'd0,  3'b001, 1'b1, 2'd0, 1'b0, 1'b0);
        vecs[1]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      5'd1,  5'd2,  3'b010, 1'b1, 2'd1, 1'b1, 1'b0);
        vecs[2]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      5'd2,  5'd0,  3'b100, 1'b1, 2'd2, 1'b1, 1'b0);
        vecs[3]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      5'd3,  5'd3,  3'b001, 1'b1, 2'd0, 1'b1, 1'b1);
        vecs[4]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      5'd1,  5'd5,  3'b010, 1'b1, 2'd1, 1'b1, 1'b0);
        vecs[5]  = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      5'd0,  5'd2,  3'b100, 1'b1, 2'd2, 1'b0, 1'b1);
        vecs[6]  = mk(3'b010, 5'd0, 5'd5, 5'd0, 32'hDEADBEEE, 5'd3,  5'd0,  3'b010, 1'b1, 2'd1, 1'b1, 1'b0);
        vecs[7]  = mk(3'b000, 5'd0, 5'd5, 5'd0, 32'hDEADBEEE, 5'd5,  5'd6,  3'b000, 1'b0, 2'd0, 1'b1, 1'b0);
        vecs[8]  = mk(3'b000, 5'd0, 5'd5, 5'd0, 32'hDEADBEEE, 5'd5,  5'd5,  3'b000, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[9]  = mk(3'b001, 5'd0, 5'd0, 5'd0, 32'h1234,     5'd0,  5'd0,  3'b001, 1'b0, 2'd0, 1'b0, 1'b0);
        vecs[10] = mk(3'b011, 5'd9, 5'd10, 5'd0, 32'h200,     5'd0,  5'd0,  3'b010, 1'b1, 2'd1, 1'b0, 1'b0);
        vecs[11] = mk(3'b001, 5'd9, 5'd10, 5'd0, 32'h200,     5'd10, 5'd9,  3'b001, 1'b1, 2'd0, 1'b1, 1'b0);
        vecs[12] = mk(3'b110, 5'd0, 5'd4, 5'd4, 32'h300,      5'd9,  5'd0,  3'b010, 1'b1, 2'd1, 1'b1, 1'b0);
        vecs[13] = mk(3'b100, 5'd0, 5'd4, 5'd4, 32'h300,      5'd4,  5'd10, 3'b100, 1'b1, 2'd2, 1'b1, 1'b0);
        vecs[14] = mk(3'b000, 5'd0, 5'd4, 5'd4, 32'h300,      5'd4,  5'd4,  3'b000, 1'b0, 2'd0, 1'b1, 1'b1);
        vecs[15] = mk(3'b000, 5'd0, 5'd4, 5'd4, 32'h300,      5'd4,  5'd0,  3'b000, 1'b0, 2'd0, 1'b0, 1'b0);

        cur_exp   = '{we: 1'b0, addr: 5'd0, data: 32'h0, id: 2'd0};
        last_push = cur_exp;

        // Reset with every requester valid: no grants, stage cleared.
        rst_n = 1'b0;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #3;
        check("reset req_ready", 64'(bus.req_ready), 64'(3'b000));
        check("reset rf_we", 64'(bus.rf_we), 64'(1'b0));
        check("reset rf_w_addr", 64'(bus.rf_w_addr), 64'(5'd0));
        check("reset rf_w_data", 64'(bus.rf_w_data), 64'(32'h0));
        check("reset wb_id", 64'(bus.wb_id), 64'(2'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            vec_t   v;
            stage_t e;
            v = vecs[i];
            drive(v.vld, v.a0, v.a1, v.a2, v.base, v.rd1, v.rd2);
            e    = last_push;
            e.we = 1'b0;
            if (v.exp_rdy != 3'b000) begin
                e.we   = v.exp_we;
                e.id   = v.exp_id;
                e.addr = (v.exp_id == 2'd0) ? v.a0 : (v.exp_id == 2'd1) ? v.a1 : v.a2;
                e.data = v.base + 32'(v.exp_id);
            end
            sb_q.push_back(e);
            last_push = e;
            #3;
            check($sformatf("v%0d req_ready", i), 64'(bus.req_ready), 64'(v.exp_rdy));
            check($sformatf("v%0d fwd_hit1", i), 64'(bus.fwd_hit1), 64'(v.exp_f1));
            check($sformatf("v%0d fwd_hit2", i), 64'(bus.fwd_hit2), 64'(v.exp_f2));
            check($sformatf("v%0d fwd_data", i), 64'(bus.fwd_data), 64'(cur_exp.data));
            @(posedge clk);
            #1;
            cur_exp = sb_q.pop_front();
            check($sformatf("v%0d rf_we", i), 64'(bus.rf_we), 64'(cur_exp.we));
            check($sformatf("v%0d rf_w_addr", i), 64'(bus.rf_w_addr), 64'(cur_exp.addr));
            check($sformatf("v%0d rf_w_data", i), 64'(bus.rf_w_data), 64'(cur_exp.data));
            check($sformatf("v%0d wb_id", i), 64'(bus.wb_id), 64'(cur_exp.id));
        end

        // Regfile contents after the table: latest same-address write wins, x0 never written.
        check("rf x5", 64'(rf_mem[5]), 64'(32'hDEADBEEF));
        check("rf x4 latest", 64'(rf_mem[4]), 64'(32'h302));
        check("rf x10", 64'(rf_mem[10]), 64'(32'h201));
        check("rf x0", 64'(rf_mem[0]), 64'(32'h0));

        // Starvation: req0 valid every cycle, req2 valid until granted.
        begin
            logic pend;
            logic prev0;
            int   gcyc;
            pend  = 1'b1;
            prev0 = 1'b0;
            gcyc  = 0;
            for (int c = 1; c <= 6 && pend; c++) begin
                drive({pend, 1'b0, 1'b1}, 5'd11, 5'd0, 5'd12, 32'h400, 5'd0, 5'd0);
                #3;
                check("starve ready only to valid", 64'(bus.req_ready & ~bus.req_valid), 64'(3'b000));
                check("starve req0 twice while req2 waits", 64'(prev0 & bus.req_ready[0]), 64'(1'b0));
                prev0 = bus.req_ready[0];
                if (bus.req_ready[2]) gcyc = c;
                @(posedge clk);
                #1;
                if (gcyc != 0) pend = 1'b0;
            end
            check("starve req2 granted within 3", 64'((gcyc >= 1) && (gcyc <= 3)), 64'(1'b1));
            check("starve wb_id", 64'(bus.wb_id), 64'(2'd2));
            check("starve rf_w_addr", 64'(bus.rf_w_addr), 64'(5'd12));
        end

        // Reset while the stage holds a write to x7: the write must be dropped.
        drive(3'b100, 5'd0, 5'd0, 5'd7, 32'h700, 5'd7, 5'd0);
        #3;
        check("midrst grant req2", 64'(bus.req_ready), 64'(3'b100));
        @(posedge clk);
        #1;
        check("midrst stage we", 64'(bus.rf_we), 64'(1'b1));
        check("midrst stage addr", 64'(bus.rf_w_addr), 64'(5'd7));
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'h800, 5'd7, 5'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst rf_we dropped", 64'(bus.rf_we), 64'(1'b0));
        check("midrst rf_w_addr", 64'(bus.rf_w_addr), 64'(5'd0));
        check("midrst wb_id", 64'(bus.wb_id), 64'(2'd0));
        check("midrst ready gated", 64'(bus.req_ready), 64'(3'b000));
        check("midrst fwd_hit1", 64'(bus.fwd_hit1), 64'(1'b0));
        @(posedge clk);
        #1;
        check("midrst rf x7 unchanged", 64'(rf_mem[7]), 64'(32'h0));
        rst_n = 1'b1;

        // Advance the pointer past req0, then reset: req0 must regain top priority.
        #3;
        check("ptr after release", 64'(bus.req_ready), 64'(3'b001));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #3;
        check("ptr reset to 0", 64'(bus.req_ready), 64'(3'b001));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
